hazard_scoreboard: RTL and testbench

// Scoreboard-based hazard controller for the in-order core pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_scoreboard_if.sv | 60 ++++++
 rtl/hazard_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard interface: decode / EX / MEM / WB inputs and pipeline control outputs.
// The master modport is the pipeline side, the slave modport is the scoreboard.
// Optional macro HAZARD_FORWARDING_EN adds the forwarding-network signals.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_wen;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              ex_redirect;
    logic              mem_busy;

    logic              if_id_en;
    logic              id_ex_en;
    logic              id_ex_bubble;
    logic              flush_if_id;
    logic              issue;
    logic              sb_err;
    logic [31:0]       stall_cycles;

`ifdef HAZARD_FORWARDING_EN
    logic [REG_AW-1:0] exm_rd;
    logic              exm_wen;
    logic              exm_is_load;
    logic [REG_AW-1:0] mwb_rd;
    logic              mwb_wen;
    logic [1:0]        fwd1_sel;
    logic [1:0]        fwd2_sel;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_wen, wb_valid, wb_rd, ex_redirect, mem_busy,
`ifdef HAZARD_FORWARDING_EN
        output exm_rd, exm_wen, exm_is_load, mwb_rd, mwb_wen,
        input  fwd1_sel, fwd2_sel,
`endif
        input  if_id_en, id_ex_en, id_ex_bubble, flush_if_id, issue,
        input  sb_err, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_wen, wb_valid, wb_rd, ex_redirect, mem_busy,
`ifdef HAZARD_FORWARDING_EN
        input  exm_rd, exm_wen, exm_is_load, mwb_rd, mwb_wen,
        output fwd1_sel, fwd2_sel,
`endif
        output if_id_en, id_ex_en, id_ex_bubble, flush_if_id, issue,
        output sb_err, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller for the five-stage in-order pipeline.
// Per-register pending-write counters decide RAW and structural stalls; a small
// IDLE/FLUSH FSM holds IF/ID flushed for FLUSH_CYCLES cycles after a redirect.
// Optional macro HAZARD_FORWARDING_EN: single in-flight producers sitting in
// EX/MEM (non-load) or MEM/WB are forwarded instead of stalled.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | normal operation, ID may issue
//   FLUSH | post-redirect window, IF/ID flushed, fc counts down to 0
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_PENDING  = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(MAX_PENDING + 1);
    localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   fc, fc_nxt;
    logic [CNT_W-1:0]  cnt [NUM_REGS];

    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] inc_hit;
    logic                raw, full, do_inc, wb_err;
    logic                if_id_en, id_ex_en, id_ex_bubble, flush_if_id, issue, stall_now;
    logic                sb_err;
    logic [31:0]         stall_cycles;

`ifdef HAZARD_FORWARDING_EN
    logic [NUM_REGS-1:0] exm_hit;
    logic [NUM_REGS-1:0] mwb_hit;
    logic [1:0]          fwd1_sel, fwd2_sel;
`endif

    // Per-register decode of WB/issue targets and the busy view seen by ID.
    // A WB retiring the last pending write is visible to ID in the same cycle
    // because the register file writes before it reads.
    always_comb begin
        busy_vec = '0;
        wb_hit   = '0;
        inc_hit  = '0;
`ifdef HAZARD_FORWARDING_EN
        exm_hit  = '0;
        mwb_hit  = '0;
`endif
        for (int i = 1; i < NUM_REGS; i++) begin
            wb_hit[i]  = sb.wb_valid && (sb.wb_rd == REG_AW'(i));
            inc_hit[i] = do_inc && (sb.id_rd == REG_AW'(i));
            busy_vec[i] = (cnt[i] != '0) &&
                          !((cnt[i] == CNT_W'(1)) && wb_hit[i]);
`ifdef HAZARD_FORWARDING_EN
            exm_hit[i] = sb.exm_wen && (sb.exm_rd == REG_AW'(i));
            mwb_hit[i] = sb.mwb_wen && (sb.mwb_rd == REG_AW'(i));
            // A lone producer past EX can be forwarded; a load still in EX/MEM cannot.
            if ((cnt[i] == CNT_W'(1)) &&
                ((exm_hit[i] && !sb.exm_is_load) || (mwb_hit[i] && !exm_hit[i])))
                busy_vec[i] = 1'b0;
`endif
        end
    end

    // Hazard detection: RAW on a used source, or destination counter saturated.
    always_comb begin
        raw  = sb.id_valid &&
               ((sb.id_rs1_used && busy_vec[sb.id_rs1]) ||
                (sb.id_rs2_used && busy_vec[sb.id_rs2]));
        full = sb.id_valid && sb.id_rd_wen && (sb.id_rd != '0) &&
               (cnt[sb.id_rd] == CNT_W'(MAX_PENDING));
        wb_err = sb.wb_valid && (sb.wb_rd != '0) && (cnt[sb.wb_rd] == '0);
    end

    // Pipeline control, priority: mem_busy > redirect/flush > stall > issue.
    always_comb begin
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        issue        = 1'b0;
        stall_now    = 1'b0;
        if (sb.mem_busy) begin
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else if (sb.ex_redirect || (state == FLUSH)) begin
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (raw || full) begin
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_now    = 1'b1;
        end else begin
            issue = sb.id_valid;
        end
        do_inc = issue && sb.id_rd_wen && (sb.id_rd != '0);
    end

    // Flush FSM next state; a frozen pipeline holds both the FSM and any
    // redirect, which the source keeps asserted until the freeze lifts.
    always_comb begin
        state_nxt = state;
        fc_nxt    = fc;
        if (!sb.mem_busy) begin
            if (sb.ex_redirect) begin
                state_nxt = FLUSH;
                fc_nxt    = FC_W'(FLUSH_CYCLES - 1);
            end else if (state == FLUSH) begin
                if (fc == '0)
                    state_nxt = IDLE;
                else
                    fc_nxt = fc - FC_W'(1);
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fc    <= '0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
        end
    end

    // Pending-write counters: +1 on issue, -1 on retire, unchanged when both hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (inc_hit[i] && !wb_hit[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (wb_hit[i] && !inc_hit[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // Sticky error on retire without a matching pending write; stall cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (wb_err)
                sb_err <= 1'b1;
            if (stall_now)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Forward mux selects; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd1_sel = 2'd0;
        fwd2_sel = 2'd0;
        if (exm_hit[sb.id_rs1])      fwd1_sel = 2'd1;
        else if (mwb_hit[sb.id_rs1]) fwd1_sel = 2'd2;
        if (exm_hit[sb.id_rs2])      fwd2_sel = 2'd1;
        else if (mwb_hit[sb.id_rs2]) fwd2_sel = 2'd2;
    end

    assign sb.fwd1_sel = fwd1_sel;
    assign sb.fwd2_sel = fwd2_sel;
`endif

    assign sb.if_id_en     = if_id_en;
    assign sb.id_ex_en     = id_ex_en;
    assign sb.id_ex_bubble = id_ex_bubble;
    assign sb.flush_if_id  = flush_if_id;
    assign sb.issue        = issue;
    assign sb.sb_err       = sb_err;
    assign sb.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_scoreboard_if #(.NUM_REGS(32)) bus ();

    hazard_scoreboard #(
        .NUM_REGS    (32),
        .MAX_PENDING (3),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected control word: {if_id_en, id_ex_en, id_ex_bubble, flush_if_id, issue}
    localparam logic [4:0] ISS = 5'b11001;
    localparam logic [4:0] IDL = 5'b11000;
    localparam logic [4:0] STL = 5'b01100;
    localparam logic [4:0] FLS = 5'b11110;
    localparam logic [4:0] FRZ = 5'b00000;

    typedef struct {
        logic        idv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wen;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        redir;
        logic        mb;
        logic [4:0]  ctl;
        logic        err;
        logic [31:0] stalls;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic idv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] rd, logic wen, logic wbv, logic [4:0] wbrd,
                                logic redir, logic mb, logic [4:0] ctl, logic err,
                                logic [31:0] stalls);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.wen = wen; v.wbv = wbv; v.wbrd = wbrd;
        v.redir = redir; v.mb = mb; v.ctl = ctl; v.err = err; v.stalls = stalls;
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", what, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid    = v.idv;
        bus.id_rs1      = v.rs1;
        bus.id_rs1_used = v.u1;
        bus.id_rs2      = v.rs2;
        bus.id_rs2_used = v.u2;
        bus.id_rd       = v.rd;
        bus.id_rd_wen   = v.wen;
        bus.wb_valid    = v.wbv;
        bus.wb_rd       = v.wbrd;
        bus.ex_redirect = v.redir;
        bus.mem_busy    = v.mb;
    endtask

    function automatic logic [4:0] ctl_now();
        return {bus.if_id_en, bus.id_ex_en, bus.id_ex_bubble, bus.flush_if_id, bus.issue};
    endfunction

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " ctl"},    {27'd0, ctl_now()}, {27'd0, v.ctl});
        check({tag, " sb_err"}, {31'd0, bus.sb_err}, {31'd0, v.err});
        check({tag, " stalls"}, bus.stall_cycles, v.stalls);
    endtask

    initial begin
        vec_t idle_v;
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);
`ifdef HAZARD_FORWARDING_EN
        bus.exm_rd = '0; bus.exm_wen = 1'b0; bus.exm_is_load = 1'b0;
        bus.mwb_rd = '0; bus.mwb_wen = 1'b0;
`endif
        drive(idle_v);
        rst_n = 1'b0;

        // RAW without forwarding: addi x5 then add x6,x5,x5; WB x5 four cycles later
        vecs.push_back(mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, ISS, 0, 0));
        for (int s = 0; s < 4; s++)
            vecs.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, STL, 0, 32'(s)));
        vecs.push_back(mk(1, 5, 1, 5, 1, 6, 1, 1, 5, 0, 0, ISS, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, IDL, 0, 4));
        vecs.push_back(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, ISS, 0, 4));
        // redirect pulse: three flush cycles, flushed writer to x8 never counted
        vecs.push_back(mk(1, 3, 1, 0, 0, 8, 1, 0, 0, 1, 0, FLS, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, FLS, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, FLS, 0, 4));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 0, 4));
        // structural stall: three writes to x7 in flight, fourth waits for a retire
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, ISS, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, STL, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, STL, 0, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, STL, 0, 6));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, ISS, 0, 7));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, IDL, 0, 7));
        vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 0, 7));
        // retire to an idle register: sticky error, counter stays 0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, IDL, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 1, 7));
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 7));
        // issue and retire x4 in the same cycle: count stays at 1
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, ISS, 1, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 4, 0, 0, ISS, 1, 7));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1, 7));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 4, 0, 0, ISS, 1, 8));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 8));
        // memory freeze with a held redirect, redirect taken after release
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 1, 1, FRZ, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 1, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 8));
        // retire during freeze still counts; frozen RAW is not a stall cycle
        vecs.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, ISS, 1, 8));
        vecs.push_back(mk(1, 10, 1, 0, 0, 0, 0, 1, 10, 0, 1, FRZ, 1, 8));
        vecs.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 8));
        // x0 is never tracked
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ISS, 1, 8));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, ISS, 1, 8));
        // second redirect inside the flush window re-arms the window
        vecs.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 1, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 1, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, FLS, 1, 8));
        vecs.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 8));
        // a busy register on an unused source port does not stall
        vecs.push_back(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, ISS, 1, 8));
        vecs.push_back(mk(1, 0, 0, 14, 0, 0, 0, 0, 0, 0, 0, ISS, 1, 8));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", idle_v);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec($sformatf("vec[%0d]", i), vecs[i]);
        end

        // asynchronous reset mid-operation: pending write to x12 is forgotten at once
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, ISS, 1, 8));
        #1;
        check("arst issue x12", {27'd0, ctl_now()}, {27'd0, ISS});
        @(negedge clk);
        drive(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1, 8));
        #1;
        check("arst pre stall", {27'd0, ctl_now()}, {27'd0, STL});
        #1;
        rst_n = 1'b0;
        #1;
        check("arst ctl", {27'd0, ctl_now()}, {27'd0, ISS});
        check("arst sb_err", {31'd0, bus.sb_err}, 32'd0);
        check("arst stalls", bus.stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = mk(1, 12, 1, 12, 1, 0, 0, 0, 0, 0, 0, ISS, 0, 0);
        drive(v);
        #1;
        check_vec("post arst", v);
        @(negedge clk);
        drive(idle_v);
        #1;
        check_vec("post arst idle", idle_v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
